// File: rtl/dsp_result_reader.sv
// Tracks DSP issue-to-P latency and captures each result into a credit-reserved FIFO.
// Optional sticky drop error: define DSP_RD_ERR_EN.
module dsp_result_reader #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic [WIDTH-1:0]         p_in,
    output logic                     credit_ok,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0] tags;
    logic [CW-1:0]      inflight;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               accept;
    logic               capture;
    logic               pop;
    logic [CW:0]        reserved;

    assign accept    = issue & credit_ok;
    assign capture   = tags[LATENCY-1];
    assign pop       = out_valid & out_ready;
    // Slots already owned by buffered results plus results still in the DSP pipe.
    assign reserved  = {1'b0, count} + {1'b0, inflight};
    assign credit_ok = reserved < (CW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tags     <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            tags     <= (tags << 1) | LATENCY'(accept);
            inflight <= inflight + CW'(accept) - CW'(capture);
            count    <= count + CW'(capture) - CW'(pop);
            if (capture)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // A tag leaving the pipe on a reset edge belongs to a discarded issue.
    always_ff @(posedge clk) begin
        if (!rst && capture)
            mem[wr_ptr] <= p_in;
    end

`ifdef DSP_RD_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (issue && !credit_ok)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_result_reader.sv
// Self-checking bench for dsp_result_reader against a queue-based reference model.
// Expected err follows DSP_RD_ERR_EN.
module tb_dsp_result_reader;

    localparam int LAT = 4;
    localparam int DEP = 8;
    localparam int W   = 48;
`ifdef DSP_RD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         issue;
    logic [W-1:0] p_in;
    logic         credit_ok;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   count;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: due-edge queue for accepted issues, value queue for buffered results.
    int           cyc = 0;
    int           pend[$];
    logic [W-1:0] mq[$];
    logic         merr = 1'b0;
    int           n_acc = 0;

    dsp_result_reader #(.LATENCY(LAT), .DEPTH(DEP), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .p_in      (p_in),
        .credit_ok (credit_ok),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd48();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic model_edge(input logic iss, input logic rdy, input logic [W-1:0] p);
        bit credit;
        credit = (mq.size() + pend.size()) < DEP;
        if (rdy && mq.size() > 0)
            void'(mq.pop_front());
        if (pend.size() > 0 && pend[0] == cyc) begin
            void'(pend.pop_front());
            mq.push_back(p);
        end
        if (iss && credit) begin
            pend.push_back(cyc + LAT);
            n_acc++;
        end
        if (iss && !credit)
            merr = 1'b1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic iss, input logic rdy, input logic [W-1:0] p);
        issue = iss;
        out_ready = rdy;
        p_in = p;
        model_edge(iss, rdy, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic iss);
        issue = iss;
        out_ready = 1'b1;
        p_in = rnd48();
        rst = 1'b1;
        pend.delete();
        mq.delete();
        merr = 1'b0;
        n_acc = 0;
        cyc++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_credit: got %b expected 1", credit_ok); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %0h expected 0", out_data); end
    endtask

    task automatic test_single();
        do_reset(1'b0);
        applyStimulus(1'b1, 1'b0, rnd48());
        for (int k = 1; k < LAT; k++)
            applyStimulus(1'b0, 1'b0, rnd48());
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early: got %b expected 0", out_valid); end
        applyStimulus(1'b0, 1'b0, 48'h1234);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 48'h1234) begin n_fail++; $display("[TB] FAIL single_data: got %0h expected 1234", out_data); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
        applyStimulus(1'b0, 1'b0, rnd48());
        n_checks++; if (out_data !== 48'h1234) begin n_fail++; $display("[TB] FAIL single_hold: got %0h expected 1234", out_data); end
        applyStimulus(1'b0, 1'b1, rnd48());
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL single_pop: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_credit_%0d: got %b expected 1", k, credit_ok); end
            applyStimulus(1'b1, 1'b0, 48'hA000 + W'(k));
        end
        n_checks++; if (credit_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_full_credit: got %b expected 0", credit_ok); end
    endtask

    task automatic test_overflow();
        for (int k = 8; k < 12; k++)
            applyStimulus(k == 8, 1'b0, 48'hA000 + W'(k));
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d expected 8", count); end
        n_checks++; if (credit_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_credit: got %b expected 0", credit_ok); end
        n_checks++; if (err !== ERR_EN) begin n_fail++; $display("[TB] FAIL ovf_err: got %b expected %b", err, ERR_EN); end
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (out_data !== 48'hA004 + W'(j)) begin n_fail++; $display("[TB] FAIL ovf_order_%0d: got %0h expected %0h", j, out_data, 48'hA004 + W'(j)); end
            applyStimulus(1'b0, 1'b1, 48'hB000 + W'(j));
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL ovf_drop_not_captured: got %0d expected 0", count); end
        n_checks++; if (err !== ERR_EN) begin n_fail++; $display("[TB] FAIL ovf_err_sticky: got %b expected %b", err, ERR_EN); end
    endtask

    task automatic test_same_edge();
        do_reset(1'b0);
        for (int k = 0; k < 7; k++)
            applyStimulus(k < 4, 1'b0, 48'hC000 + W'(k));
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("[TB] FAIL same_pre_count: got %0d expected 3", count); end
        n_checks++; if (out_data !== 48'hC004) begin n_fail++; $display("[TB] FAIL same_pre_data: got %0h expected c004", out_data); end
        applyStimulus(1'b0, 1'b1, 48'hC007);
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("[TB] FAIL same_count: got %0d expected 3", count); end
        n_checks++; if (out_data !== 48'hC005) begin n_fail++; $display("[TB] FAIL same_data: got %0h expected c005", out_data); end
    endtask

    task automatic test_reset_midflight();
        do_reset(1'b0);
        applyStimulus(1'b1, 1'b0, rnd48());
        applyStimulus(1'b0, 1'b0, rnd48());
        do_reset(1'b1);
        for (int k = 3; k < 8; k++)
            applyStimulus(1'b0, 1'b0, rnd48());
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
        n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_credit: got %b expected 1", credit_ok); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_err: got %b expected 0", err); end
        n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("[TB] FAIL mid_data: got %0h expected 0", out_data); end
    endtask

    task automatic test_random();
        int dut_pops = 0;
        logic iss;
        logic rdy;
        do_reset(1'b0);
        for (int i = 0; i < 1000 + LAT + DEP + 4; i++) begin
            if (i < 1000) begin
                iss = $urandom_range(0, 99) < 60;
                rdy = $urandom_range(0, 99) < 45;
            end else begin
                iss = 1'b0;
                rdy = 1'b1;
            end
            if (out_valid === 1'b1 && rdy)
                dut_pops++;
            applyStimulus(iss, rdy, rnd48());
            n_checks++; if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", i, out_valid, mq.size() > 0); end
            n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", i, count, mq.size()); end
            n_checks++; if (credit_ok !== ((mq.size() + pend.size()) < DEP)) begin n_fail++; $display("[TB] FAIL rnd_credit@%0d: got %b expected %b", i, credit_ok, (mq.size() + pend.size()) < DEP); end
            n_checks++; if (err !== (ERR_EN & merr)) begin n_fail++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", i, err, ERR_EN & merr); end
            if (mq.size() > 0) begin
                n_checks++; if (out_data !== mq[0]) begin n_fail++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", i, out_data, mq[0]); end
            end
        end
        n_checks++; if (dut_pops !== n_acc) begin n_fail++; $display("[TB] FAIL rnd_total: got %0d pops expected %0d", dut_pops, n_acc); end
    endtask

    initial begin
        rst = 1'b1;
        issue = 1'b0;
        out_ready = 1'b0;
        p_in = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_same_edge();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
